// File: rtl/cpu_pkg.sv
// Shared widths and ALU control encodings for the issue/ALU boundary.
package cpu_pkg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 16;

    typedef enum logic [1:0] {
        ALUC_ADD = 2'b00,
        ALUC_SUB = 2'b01,
        ALUC_AND = 2'b10,
        ALUC_OR  = 2'b11
    } aluc_e;
endpackage

// File: rtl/reg_file.sv
// General register file: two read ports, one write port, r0 reads as zero,
// and write data is forwarded to a read of the same address in the same cycle.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DW_P = DW,
    parameter int AW_P = AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW_P-1:0]   ra,
    input  logic [AW_P-1:0]   rb,
    output logic [DW_P-1:0]   rdata_a,
    output logic [DW_P-1:0]   rdata_b,
    input  logic              we,
    input  logic [AW_P-1:0]   waddr,
    input  logic [DW_P-1:0]   wdata
);
    logic [DW_P-1:0] mem [2**AW_P];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW_P; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Address zero is checked first so a write-back to r0 can never leak through the bypass.
    assign rdata_a = (ra == '0) ? '0 : ((we && waddr == ra) ? wdata : mem[ra]);
    assign rdata_b = (rb == '0) ? '0 : ((we && waddr == rb) ? wdata : mem[rb]);
endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: reads operands, selects immediate or register Y,
// and holds X/Y/aluc/out_rd in a one-entry valid/ready output register.
module alu_operand_stage
    import cpu_pkg::*;
#(
    parameter int DW_P = DW,
    parameter int AW_P = AW,
    parameter int IW_P = IW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW_P-1:0]   rs,
    input  logic [AW_P-1:0]   rt,
    input  logic [IW_P-1:0]   imm,
    input  logic              use_imm,
    input  logic              sext,
    input  logic [1:0]        op,
    input  logic [AW_P-1:0]   rd,
    input  logic              wb_en,
    input  logic [AW_P-1:0]   wb_addr,
    input  logic [DW_P-1:0]   wb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DW_P-1:0]   x,
    output logic [DW_P-1:0]   y,
    output logic [1:0]        aluc,
    output logic [AW_P-1:0]   out_rd
);
    logic [DW_P-1:0] rs_data;
    logic [DW_P-1:0] rt_data;
    logic [DW_P-1:0] imm_ext;
    logic [DW_P-1:0] y_next;
    logic            accept;

    reg_file #(.DW_P(DW_P), .AW_P(AW_P)) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .ra      (rs),
        .rb      (rt),
        .rdata_a (rs_data),
        .rdata_b (rt_data),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    assign imm_ext  = sext ? {{(DW_P-IW_P){imm[IW_P-1]}}, imm} : {{(DW_P-IW_P){1'b0}}, imm};
    assign y_next   = use_imm ? imm_ext : rt_data;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operands are captured only on accept, so a write-back during a stall
    // cannot disturb the operation already waiting for the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
            aluc      <= ALUC_ADD;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            x         <= rs_data;
            y         <= y_next;
            aluc      <= op;
            out_rd    <= rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed operations push expected
// results; a negedge monitor pops and compares on every output handshake.
module tb_alu_operand_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  aluc;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  rs, rt, rd, wb_addr, out_rd;
    logic [15:0] imm;
    logic        use_imm, sext, wb_en, out_ready, out_valid;
    logic [1:0]  op, aluc;
    logic [31:0] wb_data, x, y;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .imm(imm), .use_imm(use_imm), .sext(sext),
        .op(op), .rd(rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_ready(out_ready), .out_valid(out_valid), .x(x), .y(y),
        .aluc(aluc), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got x=%h y=%h expected no output", x, y);
            end else begin
                e = q.pop_front();
                chk("sb_x", x, e.x);
                chk("sb_y", y, e.y);
                chk("sb_aluc", {30'd0, aluc}, {30'd0, e.aluc});
                chk("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic [15:0] a_imm, input logic a_use, input logic a_sext,
                         input logic [1:0] a_op, input logic [4:0] a_rd,
                         input logic [31:0] ex, input logic [31:0] ey);
        int k;
        rs = a_rs; rt = a_rt; imm = a_imm; use_imm = a_use; sext = a_sext;
        op = a_op; rd = a_rd; in_valid = 1'b1;
        q.push_back('{x: ex, y: ey, aluc: a_op, rd: a_rd});
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    initial begin
        time t0;
        rst = 1'b1; in_valid = 0; rs = 0; rt = 0; rd = 0; imm = 0; use_imm = 0;
        sext = 0; op = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_aluc", {30'd0, aluc}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: basic issue
        wb(5'd1, 32'h0000000C);
        wb(5'd2, 32'h0000000A);
        issue(5'd1, 5'd2, 16'h0, 1'b0, 1'b0, ALUC_AND, 5'd3, 32'hC, 32'hA);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("alu_and_r", x & y, 32'h8);

        // 2: immediate extension
        issue(5'd0, 5'd0, 16'hFFF6, 1'b1, 1'b1, ALUC_ADD, 5'd4, 32'h0, 32'hFFFFFFF6);
        issue(5'd0, 5'd0, 16'hFFF6, 1'b1, 1'b0, ALUC_ADD, 5'd4, 32'h0, 32'h0000FFF6);

        // 3: bypass and r0
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
        issue(5'd5, 5'd0, 16'h0, 1'b0, 1'b0, ALUC_OR, 5'd6, 32'h55, 32'h0);
        wb_en = 1'b0;
        wb(5'd0, 32'hFFFFFFFF);
        issue(5'd0, 5'd5, 16'h0, 1'b0, 1'b0, ALUC_SUB, 5'd7, 32'h0, 32'h55);

        // 4: stall with write-back to the stalled operation's rs
        issue(5'd1, 5'd2, 16'h0, 1'b0, 1'b0, ALUC_SUB, 5'd7, 32'hC, 32'hA);
        out_ready = 1'b0;
        in_valid = 1'b1; rs = 5'd2; rt = 5'd1; use_imm = 1'b0; op = ALUC_OR; rd = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_x", x, 32'hC);
            chk("stall_y", y, 32'hA);
            chk("stall_aluc", {30'd0, aluc}, {30'd0, ALUC_SUB});
            chk("stall_rd", {27'd0, out_rd}, 32'd7);
            if (i < 2) @(posedge clk);
        end
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        out_ready = 1'b1;
        q.push_back('{x: 32'hA, y: 32'h99, aluc: ALUC_OR, rd: 5'd9});
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd1);

        // 5: throughput
        issue(5'd1, 5'd2, 16'h0, 1'b0, 1'b0, ALUC_ADD, 5'd10, 32'h99, 32'hA);
        t0 = $time;
        issue(5'd2, 5'd0, 16'h0001, 1'b1, 1'b0, ALUC_SUB, 5'd11, 32'hA, 32'h1);
        chk("tp_valid2", {31'd0, out_valid}, 32'd1);
        issue(5'd5, 5'd1, 16'h0, 1'b0, 1'b0, ALUC_AND, 5'd12, 32'h55, 32'h99);
        chk("tp_valid3", {31'd0, out_valid}, 32'd1);
        issue(5'd0, 5'd0, 16'h8000, 1'b1, 1'b1, ALUC_OR, 5'd13, 32'h0, 32'hFFFF8000);
        chk("tp_valid4", {31'd0, out_valid}, 32'd1);
        chk("tp_no_bubble", 32'($time - t0), 32'd30);

        // 6: reset while stalled, with a write-back in the same cycle
        issue(5'd5, 5'd2, 16'h0, 1'b0, 1'b0, ALUC_AND, 5'd14, 32'h55, 32'hA);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
        @(posedge clk);
        #1;
        rst = 1'b0; wb_en = 1'b0;
        q.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_x", x, 32'd0);
        chk("mid_rst_y", y, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        issue(5'd6, 5'd5, 16'h0, 1'b0, 1'b0, ALUC_ADD, 5'd15, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the ALU.
- Holds the 32x32 general register file and builds the ALU operands X and Y from register reads or an extended immediate.
- Registers X, Y and Aluc into a single output stage with a valid/ready handshake, so the ALU sees stable operands.
- Accepts write-back from the end of the pipe, with same-cycle write-to-read bypass.

Parameters:
- DW, 32, datapath width (X, Y, Wb_data).
- AW, 5, register address width; the register file has 2**AW entries.
- IW, 16, immediate width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- In_valid  in  1  decoder presents an operation.
- In_ready  out  1  stage can accept this cycle.
- Rs  in  AW  source register for X.
- Rt  in  AW  source register for Y when Use_imm=0.
- Imm  in  IW  immediate field.
- Use_imm  in  1  1: Y comes from the extended Imm.
- Sext  in  1  1: sign-extend Imm; 0: zero-extend Imm.
- Op  in  2  ALU operation code, passed through to Aluc.
- Rd  in  AW  destination register, carried alongside the operation.
- Wb_en  in  1  register write enable.
- Wb_addr  in  AW  write address.
- Wb_data  in  DW  write data.
- Out_ready  in  1  ALU/downstream can take the operation.
- Out_valid  out  1  X/Y/Aluc/Out_rd are valid.
- X  out  DW  ALU operand A.
- Y  out  DW  ALU operand B.
- Aluc  out  2  ALU control.
- Out_rd  out  AW  registered copy of Rd.

Behaviour:
- Reset (Rst=1 at an edge):
  - All registers cleared to 0; a write-back in the same cycle is ignored.
  - Out_valid=0; X=0, Y=0, Aluc=2'b00, Out_rd=0.
  - Reset has priority over every other event, including mid-stall.
- Register file:
  - r0 reads as 0 always; writes to r0 are dropped.
  - Write takes effect at the edge when Wb_en=1.
- Read path (combinational within the cycle):
  - If Wb_en=1, Wb_addr==addr and addr!=0, the read returns Wb_data (bypass); otherwise it returns the array contents.
  - The same bypass rule applies independently to the Rs and Rt ports.
- Operand build:
  - X = read(Rs).
  - Y = Use_imm ? (Sext ? sign-extend(Imm) : zero-extend(Imm)) : read(Rt).
- Handshake (one-entry output register):
  - In_ready = !Out_valid || Out_ready; purely combinational, no dependence on In_valid.
  - Accept = In_valid && In_ready. On accept: X, Y, Aluc<=Op and Out_rd<=Rd are latched, Out_valid<=1. Latency is 1 cycle.
  - No accept and Out_ready=1: Out_valid<=0.
  - Out_valid=1 and Out_ready=0: all outputs hold bit-stable; In_ready=0.
  - Back-to-back: with Out_ready=1 held, one operation is accepted every cycle.
- Operand sampling:
  - Operands are sampled at accept only.
  - A write-back arriving while an operation sits stalled in the output register does not modify that operation's X/Y.
- X and Y are don't-care when Out_valid=0; they retain their last value and are not cleared.

Decomposition:
- Shared package cpu_pkg:
  - ALUC_ADD=2'b00, ALUC_SUB=2'b01, ALUC_AND=2'b10, ALUC_OR=2'b11.
  - DW, AW, IW defaults.
- Sub-module reg_file: 2 read ports, 1 write port, r0 hardwired to zero, write bypass, synchronous reset clear.
- The operand mux and output register stay in alu_operand_stage.

Test Plan:
1. Basic issue:
   - Stimulus: write r1=32'h0000000C and r2=32'h0000000A; then issue Rs=1, Rt=2, Use_imm=0, Op=ALUC_AND, Rd=3, Out_ready=1.
   - Required: one cycle later Out_valid=1, X=32'hC, Y=32'hA, Aluc=2'b10, Out_rd=3; ALU R=32'h8.
2. Immediate extension:
   - Stimulus: Use_imm=1, Imm=16'hFFF6, Sext=1.
   - Required: Y=32'hFFFFFFF6. Repeat with Sext=0; required Y=32'h0000FFF6.
3. Write bypass and r0:
   - Stimulus: Wb_en=1, Wb_addr=5, Wb_data=32'h55 in the same cycle as an accept with Rs=5.
   - Required: X=32'h55.
   - Stimulus: Wb_addr=0, Wb_data=32'hFFFFFFFF, then read Rs=0.
   - Required: X=0.
4. Stall:
   - Stimulus: accept an operation, then Out_ready=0 for 3 cycles with In_valid=1 and different Rs/Op; also write back to the stalled operation's Rs.
   - Required: In_ready=0; X/Y/Aluc/Out_rd unchanged for all 3 cycles; the write-back does not alter X.
   - Then: release Out_ready; the pending input is accepted the next cycle.
5. Throughput:
   - Stimulus: 4 consecutive operations with In_valid=1 and Out_ready=1.
   - Required: 4 consecutive Out_valid cycles, operands in order, no bubbles.
6. Reset mid-operation:
   - Stimulus: assert Rst while Out_valid=1 and stalled, with Wb_en=1 in the same cycle.
   - Required: next cycle Out_valid=0 and X=Y=0. A subsequent read of the write target returns 0.
